// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// frame width, the default bit period for 10 MHz / 115200 baud, and the
// 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_rx_byte_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 87;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_byte_sync.sv
// Input conditioning for uart_rx_byte: a 2-flop synchroniser for the
// asynchronous uRx pin and the sample value the FSM uses at each sample point.
// Optional macro UART_RX_MAJORITY_EN: when defined, sample is a 2-of-3 vote of
// rxs over the current and two previous cycles; otherwise sample is rxs itself.
module uart_rx_sync
    import uart_rx_byte_pkg::*;
(
    input  logic clk10mhz,
    input  logic rst,
    input  logic uRx,
    output logic rxs,
    output logic sample
);

    logic meta;

    // Two-stage synchroniser; both flops reset to the idle line level.
    always_ff @(posedge clk10mhz) begin
        if (rst) begin
            meta <= 1'b1;
            rxs  <= 1'b1;
        end else begin
            meta <= uRx;
            rxs  <= meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // History of the two previous rxs values, so the vote at cnt==target
    // covers cnt==target-2, target-1 and target.
    always_ff @(posedge clk10mhz) begin
        if (rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rxs};
        end
    end

    assign sample = majority3(rxs, hist[0], hist[1]);
`else
    assign sample = rxs;
`endif

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with its own bit-timing counter. rx_int is high while a
// frame is in progress; its falling edge (with the rx_valid pulse) marks a
// new byte on rx_data. Optional macro UART_RX_MAJORITY_EN selects 2-of-3
// majority sampling inside uart_rx_sync.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk10mhz,
    input  logic       rst,
    input  logic       uRx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bitidx, bitidx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       rx_data_n;
    logic             rx_int_n;
    logic             rx_valid_n;
    logic             frame_err_n;
    logic             rxs;
    logic             sample;

    uart_rx_sync u_sync (
        .clk10mhz (clk10mhz),
        .rst      (rst),
        .uRx      (uRx),
        .rxs      (rxs),
        .sample   (sample)
    );

    // State, counters, shift register and outputs all advance together.
    always_ff @(posedge clk10mhz) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_int    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bitidx    <= bitidx_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            rx_int    <= rx_int_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
        end
    end

    // Next-state logic; the counter restarts on every state change and sample,
    // and STOP exits at mid-stop-bit so a back-to-back start edge is caught.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + CNT_W'(1);
        bitidx_n    = bitidx;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        rx_int_n    = rx_int;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rxs) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!sample) begin
                        state_n  = ST_DATA;
                        rx_int_n = 1'b1;
                        bitidx_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {sample, shreg[7:1]};
                    if (bitidx == LAST_BIT) begin
                        state_n = ST_STOP;
                    end else begin
                        bitidx_n = bitidx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n       = '0;
                    rx_data_n   = shreg;
                    rx_int_n    = 1'b0;
                    rx_valid_n  = 1'b1;
                    frame_err_n = ~sample;
                    state_n     = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed testbench for uart_rx_byte with CLKS_PER_BIT=16. Frames are
// driven one clock slot at a time right after each rising edge; a negedge
// monitor records rx_int rises and rx_valid events with their cycle numbers.
// Expected values follow the DUT's pipeline: 2 synchroniser flops, 1 cycle
// IDLE detect, then HALF_BIT cycles in START, so rx_int rises 11 cycles and
// rx_valid appears 11+9*16 = 155 cycles after the slot where start goes low.
module tb_uart_rx_byte;

    localparam int CPB = 16;

    logic       clk10mhz;
    logic       rst;
    logic       uRx;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       rx_valid;
    logic       frame_err;

    int checkCount = 0;
    int errorCount = 0;
    int cycleCount = 0;
    int lastStart  = 0;

    logic [7:0] dataQ[$];
    logic       ferrQ[$];
    int         validCycQ[$];
    int         riseCycQ[$];
    logic       prevInt   = 1'b0;
    logic       prevValid = 1'b0;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk10mhz  (clk10mhz),
        .rst       (rst),
        .uRx       (uRx),
        .rx_data   (rx_data),
        .rx_int    (rx_int),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    initial begin
        clk10mhz = 1'b0;
        forever #5 clk10mhz = ~clk10mhz;
    end

    always @(posedge clk10mhz) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record rx_int rises and every rx_valid event, checking the pulse shape.
    always @(negedge clk10mhz) begin
        if (rx_int && !prevInt) riseCycQ.push_back(cycleCount);
        if (rx_valid) begin
            dataQ.push_back(rx_data);
            ferrQ.push_back(frame_err);
            validCycQ.push_back(cycleCount);
            checkOutput("valid_on_int_fall", {30'd0, prevInt, rx_int}, 32'd2);
            checkOutput("valid_single_cycle", {31'd0, prevValid}, 32'd0);
        end
        prevInt   <= rx_int;
        prevValid <= rx_valid;
    end

    task automatic clearQueues();
        dataQ.delete();
        ferrQ.delete();
        validCycQ.delete();
        riseCycQ.delete();
    endtask

    task automatic idleLine(input int n);
        uRx = 1'b1;
        repeat (n) begin
            @(posedge clk10mhz);
            #1;
        end
    endtask

    // Drive one 8N1 frame, 16 slots per bit. glitch puts a 1-slot high pulse on
    // each data-bit sample slot; rstSlot (if >=0) pulses rst for one slot.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input bit glitch, input int rstSlot);
        for (int s = 0; s < 10 * CPB; s++) begin
            int b;
            logic v;
            b = s / CPB;
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = stopBit;
            else             v = data[b-1];
            if (glitch && b >= 1 && b <= 8 && (s % CPB) == CPB / 2) v = 1'b1;
            if (s == 0) lastStart = cycleCount;
            uRx = v;
            rst = (s == rstSlot);
            @(posedge clk10mhz);
            #1;
            if (s == rstSlot) begin
                rst = 1'b0;
                checkOutput("rst_mid_rx_int", {31'd0, rx_int}, 32'd0);
                checkOutput("rst_mid_rx_data", {24'd0, rx_data}, 32'd0);
                checkOutput("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
                checkOutput("rst_mid_frame_err", {31'd0, frame_err}, 32'd0);
            end
        end
    endtask

    task automatic checkSingleFrame(input string tag, input logic [7:0] expData, input logic expFerr);
        checkOutput({tag, "_valid_count"}, validCycQ.size(), 32'd1);
        if (dataQ.size() >= 1) begin
            checkOutput({tag, "_data"}, {24'd0, dataQ[0]}, {24'd0, expData});
            checkOutput({tag, "_frame_err"}, {31'd0, ferrQ[0]}, {31'd0, expFerr});
        end
    endtask

    initial begin
        logic [7:0] glitchExp;
        rst = 1'b1;
        uRx = 1'b1;
        repeat (5) @(posedge clk10mhz);
        #1;
        checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_rx_int", {31'd0, rx_int}, 32'd0);
        checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        idleLine(10);

        // Test 1: single frame 0x55, latency of rx_int and rx_valid.
        $display("[TB] test 1: 8'h55");
        clearQueues();
        applyStimulus(8'h55, 1'b1, 1'b0, -1);
        idleLine(20);
        checkSingleFrame("t1", 8'h55, 1'b0);
        checkOutput("t1_rise_count", riseCycQ.size(), 32'd1);
        if (riseCycQ.size() >= 1)
            checkOutput("t1_rise_latency", riseCycQ[0] - lastStart, 32'd11);
        if (validCycQ.size() >= 1)
            checkOutput("t1_valid_latency", validCycQ[0] - lastStart, 32'd155);

        // Test 2: back-to-back frames 0xA3, 0x0F with zero idle.
        $display("[TB] test 2: 8'hA3 then 8'h0F back to back");
        clearQueues();
        applyStimulus(8'hA3, 1'b1, 1'b0, -1);
        applyStimulus(8'h0F, 1'b1, 1'b0, -1);
        idleLine(20);
        checkOutput("t2_valid_count", validCycQ.size(), 32'd2);
        if (validCycQ.size() >= 2) begin
            checkOutput("t2_valid_gap", validCycQ[1] - validCycQ[0], 32'd160);
            checkOutput("t2_data0", {24'd0, dataQ[0]}, 32'hA3);
            checkOutput("t2_data1", {24'd0, dataQ[1]}, 32'h0F);
            checkOutput("t2_ferr0", {31'd0, ferrQ[0]}, 32'd0);
            checkOutput("t2_ferr1", {31'd0, ferrQ[1]}, 32'd0);
        end

        // Test 3: 4-cycle low glitch must abort in START, then 0x3C.
        $display("[TB] test 3: start glitch then 8'h3C");
        clearQueues();
        uRx = 1'b0;
        repeat (4) begin
            @(posedge clk10mhz);
            #1;
        end
        idleLine(30);
        checkOutput("t3_glitch_no_int", riseCycQ.size(), 32'd0);
        checkOutput("t3_glitch_no_valid", validCycQ.size(), 32'd0);
        applyStimulus(8'h3C, 1'b1, 1'b0, -1);
        idleLine(20);
        checkSingleFrame("t3", 8'h3C, 1'b0);

        // Test 4: 0xFF with the stop bit low gives a frame error.
        $display("[TB] test 4: 8'hFF with bad stop bit");
        clearQueues();
        applyStimulus(8'hFF, 1'b0, 1'b0, -1);
        idleLine(30);
        checkSingleFrame("t4", 8'hFF, 1'b1);
        checkOutput("t4_rise_count", riseCycQ.size(), 32'd1);

        // Test 5: reset during data bit 4 (slot 88), then 0x81.
        $display("[TB] test 5: reset mid-frame then 8'h81");
        clearQueues();
        applyStimulus(8'hFF, 1'b1, 1'b0, 5 * CPB + CPB / 2);
        idleLine(20);
        checkOutput("t5_aborted_no_valid", validCycQ.size(), 32'd0);
        clearQueues();
        applyStimulus(8'h81, 1'b1, 1'b0, -1);
        idleLine(20);
        checkSingleFrame("t5", 8'h81, 1'b0);

        // Test 6: 1-cycle high glitch on every data sample point of 0x00.
`ifdef UART_RX_MAJORITY_EN
        glitchExp = 8'h00;
`else
        glitchExp = 8'hFF;
`endif
        $display("[TB] test 6: sample-point glitches on 8'h00");
        clearQueues();
        applyStimulus(8'h00, 1'b1, 1'b1, -1);
        idleLine(20);
        checkSingleFrame("t6", glitchExp, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
